cipher_nibble_streamer: RTL and testbench

Downstream of the A5/1 keystream stage. On a start pulse it captures the 128-bit aggregated keystream and the 128-bit plaintext/ciphertext store, and XORs them. It then streams the result to the LCD writer as 32 ASCII hex characters, most-significant nibble first, using a valid/ready handshake. This replaces the free-running up-counter plus giant mux, gives correct character order, and provides an explicit done flag.

---
 rtl/cipher_nibble_streamer_pkg.sv | 15 +
 rtl/cipher_nibble_streamer_ascii.sv | 18 +
 rtl/cipher_nibble_streamer.sv | 107 ++++++++++
 tb/tb_cipher_nibble_streamer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cipher_nibble_streamer_pkg.sv
// Shared types and constants for the cipher nibble streamer and its ASCII helper.
package cipher_nibble_streamer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_A    = 8'h41;
    localparam int         NIBBLE_W   = 4;

endpackage

// File: rtl/cipher_nibble_streamer_ascii.sv
// Combinational 4-bit to uppercase ASCII hex converter, shared with the input display path.
module nibble_to_ascii
    import cipher_nibble_streamer_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble,
    output logic [7:0]          ascii
);

    always_comb begin
        ascii = ASCII_ZERO;
        if (nibble < 4'd10) begin
            ascii = ASCII_ZERO + {4'd0, nibble};
        end else begin
            ascii = ASCII_A + {4'd0, nibble - 4'd10};
        end
    end

endmodule

// File: rtl/cipher_nibble_streamer.sv
// Captures keystream ^ data on start and streams it MS nibble first as ASCII hex
// over a valid/ready handshake, with optional idle gap between characters.
//
// state | meaning
// IDLE  | waiting for start after reset
// SEND  | offering current character, waiting for char_ready
// GAP   | inter-character idle, char_valid low
// DONE  | all characters accepted, done held until next start
module cipher_nibble_streamer
    import cipher_nibble_streamer_pkg::*;
#(
    parameter  int DATA_WIDTH = 128,
    parameter  int GAP_CYCLES = 0,
    localparam int NIBBLES    = DATA_WIDTH / 4,
    localparam int CW         = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] keystream,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  char_ready,
    output logic                  char_valid,
    output logic [7:0]            char_data,
    output logic                  busy,
    output logic                  done,
    output logic [CW-1:0]         char_index
);

    localparam int          GW        = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
    localparam logic [CW-1:0] LAST     = CW'(NIBBLES - 1);

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CW-1:0]         counter;
    logic [GW-1:0]         gap_cnt;
    logic                  start_acc;
    logic                  handshake;
    logic                  last;

    assign start_acc = start && (state == IDLE || state == DONE);
    assign handshake = (state == SEND) && char_ready;
    assign last      = (counter == LAST);

    always_comb begin
        state_next = state;
        char_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start_acc) state_next = SEND;
            end
            SEND: begin
                char_valid = 1'b1;
                busy       = 1'b1;
                if (handshake) begin
                    if (last)                state_next = DONE;
                    else if (GAP_CYCLES > 0) state_next = GAP;
                    else                     state_next = SEND;
                end
            end
            GAP: begin
                busy = 1'b1;
                if (gap_cnt == '0) state_next = SEND;
            end
            DONE: begin
                done = 1'b1;
                if (start_acc) state_next = SEND;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            counter   <= '0;
            gap_cnt   <= '0;
        end else begin
            state <= state_next;
            if (start_acc) begin
                shift_reg <= keystream ^ data_in;
                counter   <= '0;
            end else if (handshake && !last) begin
                shift_reg <= shift_reg << NIBBLE_W;
                counter   <= counter + 1'b1;
            end
            // gap timer reloads on every GAP entry, counts down to terminal zero
            if (handshake && !last) begin
                gap_cnt <= GAP_LOAD;
            end else if (state == GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

    assign char_index = counter;

    nibble_to_ascii u_ascii (
        .nibble (shift_reg[DATA_WIDTH-1 -: NIBBLE_W]),
        .ascii  (char_data)
    );

endmodule

// File: tb/tb_cipher_nibble_streamer.sv
// Directed scoreboard bench for cipher_nibble_streamer (gap 0 and gap 2 instances).
module tb_cipher_nibble_streamer;

    logic         clk = 1'b0;
    logic         reset, start, char_ready;
    logic [127:0] keystream, data_in;

    logic       v0, b0, d0, vg, bg, dg;
    logic [7:0] c0, cg;
    logic [4:0] i0, ig;

    always #5 clk = ~clk;

    cipher_nibble_streamer #(.DATA_WIDTH(128), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .keystream(keystream),
        .data_in(data_in), .char_ready(char_ready), .char_valid(v0),
        .char_data(c0), .busy(b0), .done(d0), .char_index(i0));

    cipher_nibble_streamer #(.DATA_WIDTH(128), .GAP_CYCLES(2)) dutg (
        .clk(clk), .reset(reset), .start(start), .keystream(keystream),
        .data_in(data_in), .char_ready(char_ready), .char_valid(vg),
        .char_data(cg), .busy(bg), .done(dg), .char_index(ig));

    logic       sel_g = 1'b0;
    logic       vs, bs, ds;
    logic [7:0] cs;
    logic [4:0] is_;
    assign vs  = sel_g ? vg : v0;
    assign bs  = sel_g ? bg : b0;
    assign ds  = sel_g ? dg : d0;
    assign cs  = sel_g ? cg : c0;
    assign is_ = sel_g ? ig : i0;

    int         n_vec = 0;
    int         n_err = 0;
    int         hs_cnt;
    int         exp_idx;
    logic       hs;
    logic [7:0] exp_q[$];
    string      hexs = "0123456789ABCDEF";

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_run(input logic [127:0] ks, input logic [127:0] d);
        logic [127:0] x;
        logic [3:0]   n;
        x = ks ^ d;
        exp_q.delete();
        for (int i = 0; i < 32; i++) begin
            n = x[127 - 4*i -: 4];
            exp_q.push_back(hexs[n]);
        end
        exp_idx = 0;
        hs_cnt  = 0;
    endtask

    // sample at negedge, the handshake then happens at the following posedge
    task automatic tick();
        logic [7:0] e;
        @(negedge clk);
        hs = vs && char_ready;
        if (hs) begin
            if (exp_q.size() == 0) begin
                check("extra_char", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("char_data", {24'd0, cs}, {24'd0, e});
                check("char_index", {27'd0, is_}, exp_idx);
                exp_idx++;
            end
            hs_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_done(input string tag);
        int guard;
        guard = 0;
        while (!ds && guard < 300) begin
            tick();
            guard++;
        end
        check({tag, "_done"}, {31'd0, ds}, 32'd1);
        check({tag, "_count"}, hs_cnt, 32'd32);
        check({tag, "_qempty"}, exp_q.size(), 32'd0);
    endtask

    task automatic run_until_hs(input int n);
        int guard;
        guard = 0;
        while (hs_cnt < n && guard < 300) begin
            tick();
            guard++;
        end
        check("hs_reach", hs_cnt, n);
    endtask

    logic [127:0] pat1, pat2, ones;

    initial begin
        reset = 1'b1; start = 1'b0; char_ready = 1'b0;
        keystream = '0; data_in = '0;
        pat1 = 128'h0123456789ABCDEF_FEDCBA9876543210;
        pat2 = {16{8'h0F}};
        ones = '1;
        hs_cnt = 0; exp_idx = 0;
        tick(); tick();
        reset = 1'b0;

        // reset state
        check("rst_valid", {31'd0, v0}, 32'd0);
        check("rst_data", {24'd0, c0}, 32'h30);
        check("rst_busy", {31'd0, b0}, 32'd0);
        check("rst_done", {31'd0, d0}, 32'd0);
        check("rst_index", {27'd0, i0}, 32'd0);

        // reset and start together: reset wins
        reset = 1'b1; start = 1'b1; tick(); reset = 1'b0; start = 1'b0;
        check("rst_start_valid", {31'd0, v0}, 32'd0);
        check("rst_start_busy", {31'd0, b0}, 32'd0);

        // test 1: throughput, one char per cycle t+1..t+32
        char_ready = 1'b1;
        data_in = pat1; keystream = '0;
        push_run('0, pat1);
        pulse_start();
        keystream = {4{$urandom()}}; data_in = {4{$urandom()}};
        for (int k = 1; k <= 32; k++) begin
            tick();
            check("t1_hs_each_cycle", {31'd0, hs}, 32'd1);
        end
        check("t1_done", {31'd0, d0}, 32'd1);
        check("t1_busy", {31'd0, b0}, 32'd0);
        check("t1_valid", {31'd0, v0}, 32'd0);
        check("t1_index", {27'd0, i0}, 32'd31);
        tick(); tick();
        check("t1_done_hold", {31'd0, d0}, 32'd1);

        // test 2: XOR path, started from DONE
        keystream = ones; data_in = pat2;
        push_run(ones, pat2);
        pulse_start();
        check("t2_done_drop", {31'd0, d0}, 32'd0);
        check("t2_valid_t1", {31'd0, v0}, 32'd1);
        check("t2_index0", {27'd0, i0}, 32'd0);
        run_to_done("t2");

        // test 3: backpressure at index 3
        keystream = '0; data_in = pat1;
        push_run('0, pat1);
        pulse_start();
        run_until_hs(3);
        char_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t3_valid", {31'd0, v0}, 32'd1);
            check("t3_data", {24'd0, c0}, {24'd0, exp_q[0]});
            check("t3_index", {27'd0, i0}, 32'd3);
        end
        char_ready = 1'b1;
        run_to_done("t3");

        // test 5: reset mid-stream at index 10, then fresh run
        keystream = ones; data_in = pat1;
        push_run(ones, pat1);
        pulse_start();
        run_until_hs(10);
        check("t5_idx10", {27'd0, i0}, 32'd10);
        do_reset();
        check("t5_valid", {31'd0, v0}, 32'd0);
        check("t5_busy", {31'd0, b0}, 32'd0);
        check("t5_done", {31'd0, d0}, 32'd0);
        check("t5_index", {27'd0, i0}, 32'd0);
        keystream = 128'h1357_9BDF_2468_ACE0_FFFF_0000_A5A5_5A5A; data_in = pat2;
        push_run(128'h1357_9BDF_2468_ACE0_FFFF_0000_A5A5_5A5A, pat2);
        pulse_start();
        run_to_done("t5");

        // test 6: start during SEND is ignored
        keystream = '0; data_in = pat1;
        push_run('0, pat1);
        pulse_start();
        run_until_hs(5);
        keystream = ones; data_in = pat2;
        pulse_start();
        run_to_done("t6");

        // test 4: GAP_CYCLES = 2 instance
        sel_g = 1'b1;
        do_reset();
        keystream = '0; data_in = pat1;
        push_run('0, pat1);
        pulse_start();
        for (int k = 1; k <= 94; k++) begin
            tick();
            check("t4_valid_pattern", {31'd0, hs}, ((k - 1) % 3 == 0) ? 32'd1 : 32'd0);
        end
        check("t4_done", {31'd0, dg}, 32'd1);
        check("t4_count", hs_cnt, 32'd32);
        check("t4_qempty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
